vga_timing_gen: RTL and testbench

Generates the VGA raster timing that drives the image-generator stage. It walks a horizontal and a vertical phase counter across the full frame. From those counters it produces the pixel coordinates HCNT/VCNT, the active-area flag IAA, the HS/VS sync pulses, the DAC blank signal and a start-of-frame strobe. It sits between the pixel clock source and the image generator: HCNT, VCNT, IAA and VS feed that stage directly, and HS, VS and BLANK_N go to the VGA DAC.

---
 rtl/vga_timing_gen.sv | 135 +++++++++++++
 tb/tb_vga_timing_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator.
// Walks horizontal/vertical phase counters across the frame and produces
// 1-based visible pixel coordinates, active-area flag, sync pulses, DAC blank
// and a start-of-frame strobe. All outputs are registered and decoded from the
// next counter state, so they change on the same edge as the counters.
// Optional feature macro: VGA_SYNC_DELAY_EN (delays HS, VS and BLANK_N by one
// pixel to line up with a registered ROM read downstream).
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0
) (
    input  logic        VGA_CLK,
    input  logic        rst,
    input  logic        ce,
    output logic [10:0] HCNT,
    output logic [10:0] VCNT,
    output logic        IAA,
    output logic        HS,
    output logic        VS,
    output logic        BLANK_N,
    output logic        SOF
);

    localparam logic [10:0] H_LAST     = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [10:0] V_LAST     = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [10:0] hc;
    logic [10:0] vc;
    logic [10:0] hc_nxt;
    logic [10:0] vc_nxt;
    logic        h_vis_nxt;
    logic        v_vis_nxt;
    logic        iaa_nxt;
    logic        hs_act_nxt;
    logic        vs_act_nxt;

    logic [10:0] hcnt_q;
    logic [10:0] vcnt_q;
    logic        iaa_q;
    logic        hs_q;
    logic        vs_q;
    logic        sof_q;

    // Next counter position and the phase decode of that position
    always_comb begin
        hc_nxt = hc + 11'd1;
        vc_nxt = vc;
        if (hc == H_LAST) begin
            hc_nxt = '0;
            if (vc == V_LAST) begin
                vc_nxt = '0;
            end else begin
                vc_nxt = vc + 11'd1;
            end
        end
        h_vis_nxt  = (hc_nxt < H_VIS_END);
        v_vis_nxt  = (vc_nxt < V_VIS_END);
        iaa_nxt    = h_vis_nxt && v_vis_nxt;
        hs_act_nxt = (hc_nxt >= H_SYNC_BEG) && (hc_nxt < H_SYNC_END);
        vs_act_nxt = (vc_nxt >= V_SYNC_BEG) && (vc_nxt < V_SYNC_END);
    end

    // Counters and registered outputs; reset parks on the last back-porch pixel
    always_ff @(posedge VGA_CLK) begin
        if (!rst) begin
            hc     <= H_LAST;
            vc     <= V_LAST;
            hcnt_q <= '0;
            vcnt_q <= '0;
            iaa_q  <= 1'b0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            sof_q  <= 1'b0;
        end else if (ce) begin
            hc     <= hc_nxt;
            vc     <= vc_nxt;
            hcnt_q <= iaa_nxt ? (hc_nxt + 11'd1) : '0;
            vcnt_q <= iaa_nxt ? (vc_nxt + 11'd1) : '0;
            iaa_q  <= iaa_nxt;
            hs_q   <= hs_act_nxt ? HS_POL : ~HS_POL;
            vs_q   <= vs_act_nxt ? VS_POL : ~VS_POL;
            sof_q  <= (hc_nxt == '0) && (vc_nxt == '0);
        end else begin
            // strobe must not stretch while ce holds the first pixel
            sof_q  <= 1'b0;
        end
    end

    assign HCNT = hcnt_q;
    assign VCNT = vcnt_q;
    assign IAA  = iaa_q;
    assign SOF  = sof_q;

`ifdef VGA_SYNC_DELAY_EN
    logic hs_d;
    logic vs_d;
    logic blank_n_d;

    // One-pixel delay of the DAC-side signals, advancing with the pixel enable
    always_ff @(posedge VGA_CLK) begin
        if (!rst) begin
            hs_d      <= ~HS_POL;
            vs_d      <= ~VS_POL;
            blank_n_d <= 1'b0;
        end else if (ce) begin
            hs_d      <= hs_q;
            vs_d      <= vs_q;
            blank_n_d <= iaa_q;
        end
    end

    assign HS      = hs_d;
    assign VS      = vs_d;
    assign BLANK_N = blank_n_d;
`else
    assign HS      = hs_q;
    assign VS      = vs_q;
    assign BLANK_N = iaa_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed self-checking bench for vga_timing_gen.
// A full-size instance covers reset, line scan, ce gating and mid-line reset;
// a reduced-geometry instance (16x12 total, HS active-high) covers frame-level
// behaviour within a short run.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
    localparam int DLY = 1;
`else
    localparam int DLY = 0;
`endif

    logic        clk;
    logic        rst;
    logic        ce;
    logic [10:0] HCNT, VCNT;
    logic        IAA, HS, VS, BLANK_N, SOF;
    logic [10:0] s_HCNT, s_VCNT;
    logic        s_IAA, s_HS, s_VS, s_BLANK_N, s_SOF;

    int n_chk  = 0;
    int n_fail = 0;

    vga_timing_gen u_dut (
        .VGA_CLK (clk),
        .rst     (rst),
        .ce      (ce),
        .HCNT    (HCNT),
        .VCNT    (VCNT),
        .IAA     (IAA),
        .HS      (HS),
        .VS      (VS),
        .BLANK_N (BLANK_N),
        .SOF     (SOF)
    );

    vga_timing_gen #(
        .H_VISIBLE (8),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (3),
        .V_VISIBLE (6),
        .V_FRONT   (2),
        .V_SYNC    (2),
        .V_BACK    (2),
        .HS_POL    (1'b1),
        .VS_POL    (1'b0)
    ) u_small (
        .VGA_CLK (clk),
        .rst     (rst),
        .ce      (ce),
        .HCNT    (s_HCNT),
        .VCNT    (s_VCNT),
        .IAA     (s_IAA),
        .HS      (s_HS),
        .VS      (s_VS),
        .BLANK_N (s_BLANK_N),
        .SOF     (s_SOF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int hs_low, hs_first, s_vs_low, s_hs_high, s_sof_cnt, s_last_sof, s_bad_iv;
        int s_max_vcnt, s_iaa_bad, pos;
        int hold_bad, rise_cnt, rise0, rise1, s_sof_alt, s_wide;
        logic [10:0] p_hcnt, p_vcnt, ps_hcnt;
        logic        p_iaa, p_hs, ps_vs, ps_sof, cur_ce;
        int waited;

        rst = 1'b0;
        ce  = 1'b1;
        for (int i = 0; i < 5; i++) step();

        // Reset hold with ce=1
        check("rst_hcnt",    HCNT,    0);
        check("rst_vcnt",    VCNT,    0);
        check("rst_iaa",     IAA,     0);
        check("rst_hs",      HS,      1);
        check("rst_vs",      VS,      1);
        check("rst_sof",     SOF,     0);
        check("rst_blank",   BLANK_N, 0);
        check("rst_s_hs",    s_HS,    0);
        check("rst_s_vs",    s_VS,    1);

        // Line scan on full size; frame scan on the small instance
        rst = 1'b1;
        hs_low = 0; hs_first = -1;
        s_vs_low = 0; s_hs_high = 0; s_sof_cnt = 0; s_last_sof = 0; s_bad_iv = 0;
        s_max_vcnt = 0; s_iaa_bad = 0;
        for (int c = 1; c <= 801; c++) begin
            step();
            if (c == 1) begin
                check("first_hcnt",  HCNT,    1);
                check("first_vcnt",  VCNT,    1);
                check("first_iaa",   IAA,     1);
                check("first_sof",   SOF,     1);
                check("first_blank", BLANK_N, (DLY == 1) ? 0 : 1);
                check("first_s_hcnt", s_HCNT, 1);
                check("first_s_vcnt", s_VCNT, 1);
            end
            if (c == 2) begin
                check("second_sof",   SOF,     0);
                check("second_blank", BLANK_N, 1);
            end
            if (c == 640) begin
                check("c640_hcnt", HCNT, 640);
                check("c640_iaa",  IAA,  1);
            end
            if (c == 641) begin
                check("c641_hcnt",  HCNT,    0);
                check("c641_iaa",   IAA,     0);
                check("c641_blank", BLANK_N, (DLY == 1) ? 1 : 0);
            end
            if (c == 801) begin
                check("line2_hcnt", HCNT, 1);
                check("line2_vcnt", VCNT, 2);
                check("line2_vs",   VS,   1);
            end
            if (c <= 800 && HS == 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = c;
            end
            if (c <= 768) begin
                if (s_VS == 1'b0) s_vs_low++;
                if (s_HS == 1'b1) s_hs_high++;
            end
            if (s_SOF) begin
                if (s_last_sof != 0 && (c - s_last_sof) != 192) s_bad_iv++;
                s_last_sof = c;
                s_sof_cnt++;
            end
            if (int'(s_VCNT) > s_max_vcnt) s_max_vcnt = int'(s_VCNT);
            pos = (c - 1) % 192;
            if ((pos / 16) >= 6 && s_IAA) s_iaa_bad++;
            if (c == 88) begin
                check("s_corner_hcnt", s_HCNT, 8);
                check("s_corner_vcnt", s_VCNT, 6);
            end
            if (c == 89) begin
                check("s_after_hcnt", s_HCNT, 0);
                check("s_after_iaa",  s_IAA,  0);
            end
        end
        check("hs_low_cycles", hs_low,   96);
        check("hs_first_low",  hs_first, 657 + DLY);
        check("s_vs_low",      s_vs_low, 128);
        check("s_hs_high",     s_hs_high, 144);
        check("s_sof_count",   s_sof_cnt, 5);
        check("s_sof_period",  s_bad_iv, 0);
        check("s_max_vcnt",    s_max_vcnt, 6);
        check("s_iaa_blank_lines", s_iaa_bad, 0);

        // ce alternating 0/1: outputs hold across ce=0, periods double
        hold_bad = 0; rise_cnt = 0; rise0 = 0; rise1 = 0; s_sof_alt = 0; s_wide = 0;
        for (int k = 0; k < 3300; k++) begin
            p_hcnt = HCNT; p_vcnt = VCNT; p_iaa = IAA; p_hs = HS;
            ps_hcnt = s_HCNT; ps_vs = s_VS; ps_sof = s_SOF;
            cur_ce = (k % 2 == 1);
            ce = cur_ce;
            step();
            if (!cur_ce) begin
                if (HCNT !== p_hcnt || VCNT !== p_vcnt || IAA !== p_iaa || HS !== p_hs) hold_bad++;
                if (s_HCNT !== ps_hcnt || s_VS !== ps_vs) hold_bad++;
                if (SOF !== 1'b0 || s_SOF !== 1'b0) hold_bad++;
            end
            if (IAA && !p_iaa) begin
                rise_cnt++;
                if (rise_cnt == 1) rise0 = k;
                if (rise_cnt == 2) rise1 = k;
            end
            if (s_SOF) s_sof_alt++;
            if (s_SOF && ps_sof) s_wide++;
        end
        check("ce_hold",        hold_bad, 0);
        check("ce_line_starts", rise_cnt, 2);
        check("ce_line_period", rise1 - rise0, 1600);
        check("ce_s_sof_count", s_sof_alt, 8);
        check("ce_s_sof_width", s_wide, 0);

        // Reset mid-line at hc=300
        ce = 1'b1;
        waited = 0;
        while (HCNT != 11'd301 && waited < 2000) begin
            step();
            waited++;
        end
        check("reach_hc300", HCNT, 301);
        rst = 1'b0;
        step();
        check("mid_rst_hcnt",  HCNT,    0);
        check("mid_rst_vcnt",  VCNT,    0);
        check("mid_rst_iaa",   IAA,     0);
        check("mid_rst_hs",    HS,      1);
        check("mid_rst_vs",    VS,      1);
        check("mid_rst_blank", BLANK_N, 0);
        check("mid_rst_sof",   SOF,     0);
        check("mid_rst_s_hs",  s_HS,    0);
        rst = 1'b1;
        step();
        check("restart_hcnt",   HCNT,   1);
        check("restart_vcnt",   VCNT,   1);
        check("restart_sof",    SOF,    1);
        check("restart_s_hcnt", s_HCNT, 1);
        check("restart_s_sof",  s_SOF,  1);
        step();
        check("restart_hcnt2",  HCNT,   2);
        check("restart_sof2",   SOF,    0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
